// File: rtl/sha_mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one synchronous memory port among NUM_REQ hash cores, with burst locking.
// Latency: grant 1 cycle after req, mem_* registered 1 cycle after a beat, rvalid/rdata 2 cycles after a read beat.
// Backpressure: a core holds req until gnt&req (its beat); ARB_FIXED_PRIORITY_EN selects lowest-index-wins arbitration.
module sha_mem_port_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_lock,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]           rdata,
   output logic                        mem_clk,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_write_data,
   input  logic [DATA_W-1:0]           mem_read_data
);

   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {IDLE, OWN} state_t;

   state_t              state, state_nxt;
   logic [OW-1:0]       owner;
   logic [OW-1:0]       ptr;
   logic [OW-1:0]       winner;
   logic [OW-1:0]       srch_idx;
   int                  srch_sum;
   logic                found;
   logic                any_req;
   logic [BW-1:0]       beat_cnt;
   logic                beat;
   logic                release_now;
   logic [OW-1:0]       ptr_after;
   logic                rd_vld1;
   logic [OW-1:0]       rd_tag1;

   logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

   // Unflatten the per-core address/data buses so the owner can select by index
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
   end

   assign mem_clk = clk;
   assign rdata   = mem_read_data;
   assign any_req = |req;

   // Winner search: first requester at or after ptr, wrapping; ptr stays 0 in fixed-priority builds
   always_comb begin
      winner   = ptr;
      found    = 1'b0;
      srch_sum = 0;
      srch_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         srch_sum = int'(ptr) + k;
         if (srch_sum >= NUM_REQ) srch_sum = srch_sum - NUM_REQ;
         srch_idx = OW'(srch_sum);
         if (!found && req[srch_idx]) begin
            winner = srch_idx;
            found  = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: one arbitration cycle in IDLE, stay in OWN until released
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req)     state_nxt = OWN;
         OWN:     if (release_now) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: beat when the owner is requesting; release on unlock, burst limit or owner withdrawal
   always_comb begin
      beat        = (state == OWN) && req[owner];
      release_now = (state == OWN) &&
                    (!req[owner] || !req_lock[owner] || (beat_cnt == BW'(MAX_BURST - 1)));
      ptr_after   = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
   end

   // Grant, burst counter, rr pointer and registered memory pins
   always_ff @(posedge clk) begin
      if (reset) begin
         owner          <= '0;
         ptr            <= '0;
         beat_cnt       <= '0;
         gnt            <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
      end else begin
         mem_we <= beat && req_we[owner];
         if (beat) begin
            mem_addr       <= addr_arr[owner];
            mem_write_data <= wdata_arr[owner];
            beat_cnt       <= beat_cnt + 1'b1;
         end
         if (state == IDLE && any_req) begin
            owner    <= winner;
            gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            beat_cnt <= '0;
         end
         if (release_now) begin
            gnt <= '0;
`ifdef ARB_FIXED_PRIORITY_EN
            ptr <= '0;
`else
            ptr <= ptr_after;
`endif
         end
      end
   end

   // Read tag pipe, independent of the FSM so rvalid survives a grant change
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_vld1 <= 1'b0;
         rd_tag1 <= '0;
         rvalid  <= '0;
      end else begin
         rd_vld1 <= beat && !req_we[owner];
         rd_tag1 <= owner;
         rvalid  <= rd_vld1 ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << rd_tag1) : '0;
      end
   end

endmodule

// File: tb/tb_sha_mem_port_arbiter.sv
// Randomized bench for sha_mem_port_arbiter with a transaction-level reference model.
// Cores are modelled as burst generators; a behavioural memory sits on the mem_* pins.
// The model predicts grants, memory pins and tagged read returns from the arbitration rules.
module tb_sha_mem_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int MB = 16;
   localparam int NCYC = 4000;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req, req_lock, req_we;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic              mem_clk, mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_write_data;
   logic [DW-1:0]     mem_read_data;

   always #5 clk = ~clk;

   sha_mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .req(req), .req_lock(req_lock), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   // Behavioural synchronous RAM on the memory pins
   logic [DW-1:0] tb_mem [0:65535];
   logic [DW-1:0] shadow [0:65535];
   always @(posedge clk) begin
      if (mem_we === 1'b1) tb_mem[mem_addr] <= mem_write_data;
      mem_read_data <= tb_mem[mem_addr];
   end

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Reference model state
   typedef struct {int due; int core; logic [DW-1:0] data;} rd_t;
   rd_t            rdq[$];
   int             m_gnt, m_ptr, m_cnt;
   logic           exp_we;
   logic [AW-1:0]  exp_addr;
   logic [DW-1:0]  exp_wd;
   logic           last_read_beat;

   // Core stimulus state
   int             c_rem [N];
   logic           c_we  [N];
   logic [AW-1:0]  c_addr[N];
   logic [DW-1:0]  c_wd  [N];

   task automatic new_op(input int i);
      c_we[i]   = 1'($urandom_range(0, 1));
      c_addr[i] = 16'($urandom) & 16'hF00F;
      c_wd[i]   = $urandom;
   endtask

   initial begin
      logic [N-1:0]  eg, erv, prev_gnt, prev_req;
      logic [DW-1:0] erd;
      logic          has_rd, prev_rst, rst, arm, any;
      int            o;

      for (int a = 0; a < 65536; a++) begin
         tb_mem[a] = '0;
         shadow[a] = '0;
      end
      for (int i = 0; i < N; i++) begin
         c_rem[i] = 0;
         new_op(i);
      end
      reset = 1'b1; req = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      m_gnt = -1; m_ptr = 0; m_cnt = 0;
      exp_we = 1'b0; exp_addr = '0; exp_wd = '0; last_read_beat = 1'b0;
      prev_gnt = '0; prev_req = '0; prev_rst = 1'b1; arm = 1'b0;

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cyc = c;

         // Compare DUT against the model's prediction for this cycle
         eg = '0;
         if (m_gnt >= 0) eg[m_gnt] = 1'b1;
         chk("gnt", 64'(gnt), 64'(eg));
         chk("mem_we", 64'(mem_we), 64'(exp_we));
         chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
         chk("mem_write_data", 64'(mem_write_data), 64'(exp_wd));
         erv = '0; erd = '0; has_rd = 1'b0;
         foreach (rdq[k]) begin
            if (rdq[k].due == c) begin
               erv[rdq[k].core] = 1'b1;
               erd = rdq[k].data;
               has_rd = 1'b1;
            end
         end
         chk("rvalid", 64'(rvalid), 64'(erv));
         if (has_rd) chk("rdata", 64'(rdata), 64'(erd));
         while (rdq.size() > 0 && rdq[0].due <= c) void'(rdq.pop_front());

         // Cores retire the beat they got last cycle
         if (!prev_rst) begin
            for (int i = 0; i < N; i++) begin
               if (prev_gnt[i] && prev_req[i]) begin
                  c_rem[i]--;
                  if (c_rem[i] > 0 && $urandom_range(0, 7) == 0) c_rem[i] = 0;
                  if (c_rem[i] > 0) new_op(i);
               end
            end
         end
         // Idle cores may start a new burst
         for (int i = 0; i < N; i++) begin
            if (c_rem[i] == 0 && $urandom_range(0, 3) == 0) begin
               c_rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 24)) : 1;
               new_op(i);
            end
         end

         // Occasional reset one cycle after a read beat
         if (c % 700 == 350) arm = 1'b1;
         rst = (c < 3) || (arm && last_read_beat);
         if (rst && c >= 3) arm = 1'b0;

         reset = rst;
         for (int i = 0; i < N; i++) begin
            req[i]      = (c_rem[i] > 0);
            req_lock[i] = (c_rem[i] > 1);
            req_we[i]   = c_we[i];
            req_addr[i*AW +: AW]  = c_addr[i];
            req_wdata[i*DW +: DW] = c_wd[i];
         end

         // Model: predict next cycle from this cycle's inputs
         last_read_beat = 1'b0;
         if (rst) begin
            m_gnt = -1; m_ptr = 0; m_cnt = 0;
            exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
            rdq.delete();
         end else if (m_gnt < 0) begin
            exp_we = 1'b0;
            any = 1'b0;
            for (int k = 0; k < N; k++) begin
               if (!any && req[(m_ptr + k) % N]) begin
                  m_gnt = (m_ptr + k) % N;
                  any = 1'b1;
               end
            end
            m_cnt = 0;
         end else begin
            o = m_gnt;
            if (req[o]) begin
               exp_we   = c_we[o];
               exp_addr = c_addr[o];
               exp_wd   = c_wd[o];
               if (c_we[o]) shadow[c_addr[o]] = c_wd[o];
               else begin
                  rdq.push_back('{due: c + 2, core: o, data: shadow[c_addr[o]]});
                  last_read_beat = 1'b1;
               end
               m_cnt++;
               if (!req_lock[o] || m_cnt == MB) m_gnt = -1;
            end else begin
               exp_we = 1'b0;
               m_gnt = -1;
            end
            if (m_gnt < 0) begin
`ifdef ARB_FIXED_PRIORITY_EN
               m_ptr = 0;
`else
               m_ptr = (o + 1) % N;
`endif
            end
         end

         prev_gnt = gnt;
         prev_req = req;
         prev_rst = rst;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
